// File: rtl/mcpu_core_fq_pkg.sv
// Shared types and widths for the fetch-to-decode instruction-packet queue.
package mcpu_core_fq_pkg;

  localparam int unsigned PC_W  = 28;
  localparam int unsigned PKT_W = 128;

  typedef struct packed {
    logic [PC_W-1:0]  virtpc;
    logic [PKT_W-1:0] packet;
    logic             pf;
  } fq_entry_t;

endpackage

// File: rtl/mcpu_core_fq_mem.sv
// DEPTH-entry register file for the fetch queue: one write port, async read, no storage reset.
module mcpu_core_fq_mem
  import mcpu_core_fq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fq_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fq_entry_t     o_rdata
);

  fq_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mcpu_core_fetch_queue.sv
// In-order instruction-packet queue from fetch to decode, flushable in one cycle.
// Define MCPU_CORE_FQ_BYPASS_EN to forward a push straight to decode when the queue is empty.
module mcpu_core_fetch_queue
  import mcpu_core_fq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             pipe_flush,
  input  logic             f2fq_valid,
  input  logic [PC_W-1:0]  f2fq_virtpc,
  input  logic [PKT_W-1:0] f2fq_packet,
  input  logic             f2fq_pf,
  output logic             fq2f_ready,
  output logic             fq2d_valid,
  output logic [PC_W-1:0]  fq2d_virtpc,
  output logic [PKT_W-1:0] fq2d_packet,
  output logic             fq2d_pf,
  input  logic             d2fq_ready,
  output logic [CW-1:0]    fq_count
);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic      w_empty;
  logic      w_push;
  logic      w_write;
  logic      w_mem_pop;
  fq_entry_t w_wdata;
  fq_entry_t w_rdata;
  fq_entry_t w_head;

  assign w_empty    = (r_count == '0);
  assign fq2f_ready = (r_count != CW'(DEPTH));
  assign w_push     = f2fq_valid & fq2f_ready & ~pipe_flush;
  assign w_mem_pop  = ~w_empty & d2fq_ready & ~pipe_flush;
  assign w_wdata    = '{virtpc: f2fq_virtpc, packet: f2fq_packet, pf: f2fq_pf};

`ifdef MCPU_CORE_FQ_BYPASS_EN
  // Empty queue: head is the incoming return; if decode takes it, it is never stored.
  assign fq2d_valid = w_empty ? (f2fq_valid & ~pipe_flush) : 1'b1;
  assign w_head     = w_empty ? w_wdata : w_rdata;
  assign w_write    = w_push & ~(w_empty & d2fq_ready);
`else
  assign fq2d_valid = ~w_empty;
  assign w_head     = w_rdata;
  assign w_write    = w_push;
`endif

  assign fq2d_virtpc = w_head.virtpc;
  assign fq2d_packet = w_head.packet;
  assign fq2d_pf     = fq2d_valid & w_head.pf;
  assign fq_count    = r_count;

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst || pipe_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_mem_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_write && !w_mem_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_write && w_mem_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  mcpu_core_fq_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clkrst_core_clk),
    .i_we    (w_write),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_mcpu_core_fetch_queue.sv
// Directed bench for mcpu_core_fetch_queue with hand-computed expectations.
module tb_mcpu_core_fetch_queue;
  import mcpu_core_fq_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [PC_W-1:0]  in_pc = '0;
  logic [PKT_W-1:0] in_pkt = '0;
  logic             in_pf = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [PKT_W-1:0] out_pkt;
  logic             out_pf;
  logic             dec_ready = 1'b0;
  logic [2:0]       count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcpu_core_fetch_queue #(
    .DEPTH (4)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .pipe_flush      (flush),
    .f2fq_valid      (in_valid),
    .f2fq_virtpc     (in_pc),
    .f2fq_packet     (in_pkt),
    .f2fq_pf         (in_pf),
    .fq2f_ready      (in_ready),
    .fq2d_valid      (out_valid),
    .fq2d_virtpc     (out_pc),
    .fq2d_packet     (out_pkt),
    .fq2d_pf         (out_pf),
    .d2fq_ready      (dec_ready),
    .fq_count        (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic pf);
    in_valid = v;
    in_pc    = pc;
    in_pkt   = {4{4'h0, pc}};
    in_pf    = pf;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_pf", 128'(out_pf), 128'd0);
    check("rst_ready", 128'(in_ready), 128'd1);
    check("rst_count", 128'(count), 128'd0);

    // Single push, decode stalled
    drive(1'b1, 28'h10, 1'b0);
`ifdef MCPU_CORE_FQ_BYPASS_EN
    #1;
    check("byp_stalled_valid", 128'(out_valid), 128'd1);
`else
    #1;
    check("nobyp_same_cycle_valid", 128'(out_valid), 128'd0);
`endif
    tick();
    check("push1_valid", 128'(out_valid), 128'd1);
    check("push1_pc", 128'(out_pc), 128'h10);
    check("push1_pkt", out_pkt, {4{32'h0000010}});
    check("push1_count", 128'(count), 128'd1);

    // Fill to DEPTH
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 28'(28'h10 + i), 1'b0);
      tick();
    end
    check("full_count", 128'(count), 128'd4);
    check("full_ready", 128'(in_ready), 128'd0);
    check("full_head", 128'(out_pc), 128'h10);

    // Full + pop: push of 0x14 refused
    drive(1'b1, 28'h14, 1'b0);
    dec_ready = 1'b1;
    #1;
    check("full_pop_ready", 128'(in_ready), 128'd0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("after_pop_count", 128'(count), 128'd3);
    check("pop_1", 128'(out_pc), 128'h11);
    tick();
    check("pop_2", 128'(out_pc), 128'h12);
    tick();
    check("pop_3", 128'(out_pc), 128'h13);
    tick();
    check("drained_valid", 128'(out_valid), 128'd0);
    check("drained_count", 128'(count), 128'd0);
    dec_ready = 1'b0;

    // Streaming across pointer wrap
    drive(1'b1, 28'h100, 1'b0);
    tick();
    dec_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 28'(28'h100 + i), 1'b0);
      check("stream_pc", 128'(out_pc), 128'(28'h100 + i - 1));
      check("stream_count", 128'(count), 128'd1);
      tick();
    end
    check("stream_last_pc", 128'(out_pc), 128'h114);
    drive(1'b0, '0, 1'b0);
    tick();
    check("stream_empty", 128'(out_valid), 128'd0);
    dec_ready = 1'b0;

    // Flush with three entries and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 28'(28'h30 + i), 1'b0);
      tick();
    end
    check("preflush_count", 128'(count), 128'd3);
    drive(1'b1, 28'h33, 1'b0);
    flush = 1'b1;
    dec_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_count", 128'(count), 128'd0);
    check("flush_ready", 128'(in_ready), 128'd1);
    check("flush_pf", 128'(out_pf), 128'd0);
    tick();
    check("flush_no_ghost", 128'(out_valid), 128'd0);
    dec_ready = 1'b0;

    // Page-fault flag travels with its entry only
    drive(1'b1, 28'h40, 1'b1);
    tick();
    drive(1'b1, 28'h41, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("pf_head_pc", 128'(out_pc), 128'h40);
    check("pf_head_flag", 128'(out_pf), 128'd1);
    dec_ready = 1'b1;
    tick();
    check("pf_next_pc", 128'(out_pc), 128'h41);
    check("pf_next_flag", 128'(out_pf), 128'd0);
    tick();
    check("pf_empty_flag", 128'(out_pf), 128'd0);
    check("pf_empty_count", 128'(count), 128'd0);

    // Push into empty queue with decode ready
    drive(1'b1, 28'h20, 1'b0);
    #1;
`ifdef MCPU_CORE_FQ_BYPASS_EN
    check("byp_valid", 128'(out_valid), 128'd1);
    check("byp_pc", 128'(out_pc), 128'h20);
    tick();
    drive(1'b0, '0, 1'b0);
    check("byp_count", 128'(count), 128'd0);
    check("byp_not_stored", 128'(out_valid), 128'd0);
`else
    check("nobyp_valid", 128'(out_valid), 128'd0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("nobyp_count", 128'(count), 128'd1);
    check("nobyp_pc", 128'(out_pc), 128'h20);
    tick();
    check("nobyp_drained", 128'(count), 128'd0);
`endif
    dec_ready = 1'b0;

    // Reset mid-operation acts like a flush
    drive(1'b1, 28'h50, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("midrst_count", 128'(count), 128'd0);
    check("midrst_valid", 128'(out_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
